mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Responder side of the pipeline's split instruction/data memory ports. Accepts
//  inst_* and data_* requests from pipeline_datapath and serialises them onto one
//  shared physical memory port (pmem_*). Returns registered read data and a
//  one-cycle resp pulse to the requester. Sits between the datapath and the
//  memory/cache level.
// PARAMETERS
//  MAX_DATA_STREAK  4  consecutive data grants allowed while inst_read is pending;
//                      the next grant then goes to inst (range 1..15)
// PORTS
//  clk               in   1   single clock; all state updates on posedge clk
//  reset             in   1   synchronous, active-high
//  inst_read         in   1   instruction read request; held until inst_resp
//  inst_addr         in   32  instruction address; stable while inst_read
//  inst_resp         out  1   one-cycle pulse: inst_rdata valid
//  inst_rdata        out  32  registered instruction word
//  data_read         in   1   data read request; held until data_resp
//  data_write        in   1   data write request; held until data_resp
//  data_mbe          in   4   byte enables for a write
//  data_addr         in   32  data address
//  data_wdata        in   32  write data
//  data_resp         out  1   one-cycle pulse: data read/write complete
//  data_rdata        out  32  registered load data
//  pmem_read         out  1   shared-port read strobe
//  pmem_write        out  1   shared-port write strobe
//  pmem_addr         out  32  shared-port address
//  pmem_wdata        out  32  shared-port write data
//  pmem_byte_enable  out  4   shared-port byte enables (4'hF on reads)
//  pmem_resp         in   1   memory completion, single cycle
//  pmem_rdata        in   32  memory read data, valid with pmem_resp
// BEHAVIOUR
//  Reset: state=IDLE, streak=0; all outputs 0 (rdata regs 32'h0, pmem_* low/0).
//  FSM states: IDLE, INST_BUSY, DATA_BUSY, INST_DONE, DATA_DONE.
//  IDLE: arbitrate on current inputs; captures addr/wdata/mbe/op into regs.
//   - data_req=(data_read|data_write). Data has priority (it is the older instr)
//     unless inst_read && streak==MAX_DATA_STREAK, then inst wins.
//   - grant data -> DATA_BUSY; streak += inst_read ? 1 : 0 (saturates).
//   - grant inst -> INST_BUSY; streak <= 0. No request -> stay IDLE.
//  *_BUSY: pmem_* driven from captured regs only (never from live inputs);
//   strobe held until pmem_resp. On pmem_resp: latch pmem_rdata into
//   inst_rdata/data_rdata (data_rdata unchanged for writes), go *_DONE.
//  *_DONE: assert matching *_resp for exactly one cycle, pmem strobes low,
//   -> IDLE. Requester sees resp and may change its request at the next edge;
//   IDLE therefore never re-grants the just-completed request.
//  Latency: req seen in IDLE at cycle N; pmem strobe in N+1; pmem_resp at cycle
//   M>=N+1 -> resp pulse at M+1. Minimum 2 cycles; one transaction outstanding.
//  data_read && data_write together: write wins (protocol violation, asserted).
//  pmem_byte_enable = captured data_mbe on writes, 4'hF on reads.
//  pmem_resp outside *_BUSY: ignored. inst_resp and data_resp never both high.
//  Reset mid-operation: next edge -> IDLE, pmem strobes drop, pending resp is
//   never issued; downstream must tolerate the abandoned access.
//  Requests dropped while *_BUSY: transaction still completes, resp still pulses.
// STRUCTURE
//  Package mem_arb_pkg: arb_state_e enum (5 states), PMEM_BE_READ=4'hF, width
//  localparams (ADDR_W=32, DATA_W=32, MBE_W=4). Flat implementation: one FSM,
//  capture regs, streak counter; no sub-module required.
// TESTING
//  1 inst_read, addr 32'h60, pmem_resp 3 cycles later w/ 32'h00000013 ->
//    pmem_read/addr 32'h60 held 3 cycles; inst_resp 1 cycle, inst_rdata=32'h13.
//  2 data_write addr 32'h100, mbe 4'b0011, wdata 32'hDEADBEEF -> pmem_write,
//    pmem_byte_enable 4'b0011, pmem_wdata matches; data_resp pulse; rdata kept.
//  3 inst_read and data_read in same IDLE cycle -> data served first, then inst;
//    never two resps same cycle.
//  4 inst_read held, data_read re-asserted after every data_resp, MAX=4 -> 4 data
//    grants, then 1 inst grant, streak back to 0.
//  5 reset pulse during DATA_BUSY -> next cycle IDLE, pmem strobes 0, no
//    data_resp; later late pmem_resp ignored.
//  6 pmem_resp asserted in IDLE with no request -> no resp, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MBE_W    = 4;
  localparam int STREAK_W = 4;

  // Reads always fetch the full word.
  localparam logic [MBE_W-1:0] PMEM_BE_READ = 4'hF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INST_BUSY = 3'd1,
    DATA_BUSY = 3'd2,
    INST_DONE = 3'd3,
    DATA_DONE = 3'd4
  } arb_state_e;

  // Saturating increment for the data-streak counter.
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == {STREAK_W{1'b1}}) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises split instruction/data requests onto one shared memory port.
// Data requests normally win (they belong to the older instruction), but a
// waiting instruction fetch is forced through after MAX_DATA_STREAK data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_read,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_resp,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [MBE_W-1:0]  data_mbe,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_resp,
  output logic [DATA_W-1:0] data_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [MBE_W-1:0]  pmem_byte_enable,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e            state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [MBE_W-1:0]      mbe_reg;
  logic                  write_reg;
  logic [STREAK_W-1:0]   streak_reg;
  logic [DATA_W-1:0]     inst_rdata_reg;
  logic [DATA_W-1:0]     data_rdata_reg;

  logic data_req;
  logic inst_forced;
  logic grant_data;
  logic grant_inst;

  assign data_req    = data_read | data_write;
  assign inst_forced = inst_read && (streak_reg == MAX_STREAK);
  assign inst_rdata  = inst_rdata_reg;
  assign data_rdata  = data_rdata_reg;

  // Next-state, grant decision and port outputs; pmem_* only ever come from captured regs.
  always_comb begin
    state_next       = state_reg;
    grant_data       = 1'b0;
    grant_inst       = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_addr        = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    inst_resp        = 1'b0;
    data_resp        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (data_req && !inst_forced) begin
          grant_data = 1'b1;
          state_next = DATA_BUSY;
        end else if (inst_read) begin
          grant_inst = 1'b1;
          state_next = INST_BUSY;
        end
      end
      INST_BUSY: begin
        pmem_read        = 1'b1;
        pmem_addr        = addr_reg;
        pmem_byte_enable = PMEM_BE_READ;
        if (pmem_resp) state_next = INST_DONE;
      end
      DATA_BUSY: begin
        pmem_read        = !write_reg;
        pmem_write       = write_reg;
        pmem_addr        = addr_reg;
        pmem_wdata       = wdata_reg;
        pmem_byte_enable = write_reg ? mbe_reg : PMEM_BE_READ;
        if (pmem_resp) state_next = DATA_DONE;
      end
      INST_DONE: begin
        inst_resp  = 1'b1;
        state_next = IDLE;
      end
      DATA_DONE: begin
        data_resp  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, request capture on grant, and streak bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      mbe_reg    <= '0;
      write_reg  <= 1'b0;
      streak_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_data) begin
        addr_reg  <= data_addr;
        wdata_reg <= data_wdata;
        mbe_reg   <= data_mbe;
        // Simultaneous read and write is illegal; the write takes precedence.
        write_reg <= data_write;
        if (inst_read) streak_reg <= streak_inc(streak_reg);
      end else if (grant_inst) begin
        addr_reg   <= inst_addr;
        wdata_reg  <= '0;
        mbe_reg    <= PMEM_BE_READ;
        write_reg  <= 1'b0;
        streak_reg <= '0;
      end
    end
  end

  // Read-data return registers; a write completion leaves data_rdata untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else if (pmem_resp) begin
      if (state_reg == INST_BUSY) inst_rdata_reg <= pmem_rdata;
      if (state_reg == DATA_BUSY && !write_reg) data_rdata_reg <= pmem_rdata;
    end
  end

  a_no_read_write: assert property (@(posedge clk) disable iff (reset) !(data_read && data_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;
  logic [31:0] pmem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_resp(inst_resp), .inst_rdata(inst_rdata),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_resp(data_resp), .data_rdata(data_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: data grants since the last inst grant, and last returned words.
  int          streak_m;
  logic [31:0] inst_rdata_m;
  logic [31:0] data_rdata_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_bit({tag, "_pmem_read"}, pmem_read, 1'b0);
    check_bit({tag, "_pmem_write"}, pmem_write, 1'b0);
    check_bit({tag, "_inst_resp"}, inst_resp, 1'b0);
    check_bit({tag, "_data_resp"}, data_resp, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
    pmem_resp = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    streak_m = 0;
    inst_rdata_m = 32'h0;
    data_rdata_m = 32'h0;
  endtask

  // Call in IDLE with requests applied; returns in the DONE cycle with the served request dropped.
  task automatic run_txn(input int lat, input logic [31:0] rdv, output bit was_data);
    bit          wr;
    logic [31:0] a, wd;
    logic [3:0]  be;
    was_data = (data_read || data_write) && !(inst_read && streak_m == MAX);
    if (was_data) begin
      wr = data_write;
      a  = data_addr;
      wd = data_wdata;
      be = wr ? data_mbe : 4'hF;
      if (inst_read && streak_m < 15) streak_m++;
    end else begin
      wr = 1'b0;
      a  = inst_addr;
      wd = 32'h0;
      be = 4'hF;
      streak_m = 0;
    end
    tick();
    for (int c = 0; c < lat; c++) begin
      check_bit("busy_pmem_read", pmem_read, !wr);
      check_bit("busy_pmem_write", pmem_write, wr);
      check("busy_pmem_addr", pmem_addr, a);
      check("busy_pmem_be", {28'h0, pmem_byte_enable}, {28'h0, be});
      if (wr) check("busy_pmem_wdata", pmem_wdata, wd);
      check_bit("busy_no_inst_resp", inst_resp, 1'b0);
      check_bit("busy_no_data_resp", data_resp, 1'b0);
      // Live inputs wander; the shared port must keep showing the captured request.
      inst_addr  = $urandom;
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_mbe   = 4'($urandom);
      if (c == lat - 1) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdv;
      end else begin
        pmem_rdata = $urandom;
      end
      tick();
      pmem_resp = 1'b0;
    end
    if (was_data && !wr) data_rdata_m = rdv;
    if (!was_data) inst_rdata_m = rdv;
    check_bit("done_inst_resp", inst_resp, !was_data);
    check_bit("done_data_resp", data_resp, was_data);
    check("done_inst_rdata", inst_rdata, inst_rdata_m);
    check("done_data_rdata", data_rdata, data_rdata_m);
    check_bit("done_pmem_read", pmem_read, 1'b0);
    check_bit("done_pmem_write", pmem_write, 1'b0);
    if (was_data) begin
      data_read  = 1'b0;
      data_write = 1'b0;
    end else begin
      inst_read = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    bit wd;
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; data_mbe = 4'h0;
    pmem_rdata = 32'h0;
    do_reset();
    reset = 1'b1;
    tick();
    check_quiet("reset");
    check("reset_inst_rdata", inst_rdata, 32'h0);
    check("reset_data_rdata", data_rdata, 32'h0);
    check("reset_pmem_addr", pmem_addr, 32'h0);
    check("reset_pmem_wdata", pmem_wdata, 32'h0);
    check("reset_pmem_be", {28'h0, pmem_byte_enable}, 32'h0);
    reset = 1'b0;

    // Instruction fetch with three-cycle memory latency.
    inst_read = 1'b1; inst_addr = 32'h60;
    run_txn(3, 32'h00000013, wd);
    check("t1_inst_rdata", inst_rdata, 32'h13);
    tick();

    // Partial write; load data register must keep its value.
    data_write = 1'b1; data_addr = 32'h100; data_mbe = 4'b0011; data_wdata = 32'hDEADBEEF;
    run_txn(2, $urandom, wd);
    check("t2_data_rdata_kept", data_rdata, 32'h0);
    tick();

    // Simultaneous requests: data first, then the fetch.
    inst_read = 1'b1; inst_addr = $urandom; data_read = 1'b1; data_addr = $urandom;
    run_txn(1, $urandom, wd);
    check_bit("t3_first_is_data", wd, 1'b1);
    tick();
    run_txn(2, $urandom, wd);
    check_bit("t3_second_is_inst", wd, 1'b0);
    tick();

    // Starvation guard: four data grants, then the held fetch goes through.
    do_reset();
    inst_read = 1'b1; inst_addr = $urandom; data_read = 1'b1; data_addr = $urandom;
    for (int k = 0; k < 5; k++) begin
      run_txn($urandom_range(3, 1), $urandom, wd);
      check_bit("t4_grant_pattern", wd, k < 4);
      if (k < 4) begin
        data_read = 1'b1;
        data_addr = $urandom;
      end else begin
        inst_read = 1'b1;
      end
      tick();
    end
    run_txn(1, $urandom, wd);
    check_bit("t4_streak_cleared_data_wins", wd, 1'b1);
    tick();
    run_txn(1, $urandom, wd);
    check_bit("t4_then_inst", wd, 1'b0);
    tick();

    // Reset while a data access is outstanding; a late completion is ignored.
    data_read = 1'b1; data_addr = 32'h200;
    tick();
    check_bit("t5_busy_strobe", pmem_read, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_read = 1'b0;
    streak_m = 0; inst_rdata_m = 32'h0; data_rdata_m = 32'h0;
    check_quiet("t5_after_reset");
    pmem_resp = 1'b1; pmem_rdata = 32'hCAFEF00D;
    tick();
    pmem_resp = 1'b0;
    check_quiet("t5_late_resp");
    tick();
    check_quiet("t5_late_resp_next");
    check("t5_data_rdata", data_rdata, 32'h0);

    // Stray memory completions while idle.
    for (int k = 0; k < 3; k++) begin
      pmem_resp = 1'b1; pmem_rdata = $urandom;
      tick();
      check_quiet("t6_idle_stray_resp");
    end
    pmem_resp = 1'b0;
    inst_read = 1'b1; inst_addr = 32'h44;
    run_txn(1, 32'h12345678, wd);
    check_bit("t6_still_idle_grants_inst", wd, 1'b0);
    tick();

    // Randomized traffic with persistent pending requests.
    for (int i = 0; i < 40; i++) begin
      if (!inst_read && $urandom_range(1, 0) == 1) begin
        inst_read = 1'b1;
        inst_addr = $urandom;
      end
      if (!data_read && !data_write && $urandom_range(2, 0) != 0) begin
        if ($urandom_range(1, 0) == 1) data_write = 1'b1;
        else data_read = 1'b1;
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_mbe   = 4'($urandom);
      end
      if (!inst_read && !data_read && !data_write) begin
        inst_read = 1'b1;
        inst_addr = $urandom;
      end
      run_txn($urandom_range(4, 1), $urandom, wd);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
